// File: rtl/can_reg_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// can_reg_pkg
// Shared definitions for the CAN register-access arbiter: the FSM state
// encoding, the requester identity, the wait-counter width and the address
// maps that decide which register addresses may be written or read.
// No ports; imported by the interface, the arbiter core and the top level.
// ---------------------------------------------------------------------------
package can_reg_pkg;

   // Width of the post-strobe wait counter (enough for up to 7 wait cycles)
   localparam int WAIT_CNT_W = 3;

   // Writable register map: four low registers, one single register at
   // 0x05, a middle block and a high block. Everything else is read-only
   // or unimplemented.
   localparam logic [31:0] WR_LOW_HI  = 32'h03;
   localparam logic [31:0] WR_SINGLE  = 32'h05;
   localparam logic [31:0] WR_MID_LO  = 32'h08;
   localparam logic [31:0] WR_MID_HI  = 32'h11;
   localparam logic [31:0] WR_HIGH_LO = 32'h18;
   localparam logic [31:0] WR_HIGH_HI = 32'h20;

   // Readable register map: one contiguous block starting at zero
   localparam logic [31:0] RD_HI      = 32'h20;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      SRC_HOST,
      SRC_CORE
   } src_t;

   // Callers zero-extend their address so the map stays width-agnostic
   function automatic logic is_wr_addr_valid(input logic [31:0] addr);
      return (addr <= WR_LOW_HI) ||
             (addr == WR_SINGLE) ||
             ((addr >= WR_MID_LO)  && (addr <= WR_MID_HI)) ||
             ((addr >= WR_HIGH_LO) && (addr <= WR_HIGH_HI));
   endfunction

   function automatic logic is_rd_addr_valid(input logic [31:0] addr);
      return (addr <= RD_HI);
   endfunction

endpackage

// File: rtl/can_reg_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// can_reg_access_arbiter_if
// Bundles every non-clock signal of the register-access arbiter.
//   host_*     : host bus request/response (read or write)
//   core_*     : CAN core status write-back request/response (write only)
//   wr_en/rd_en/addr/bus_data/reg_r_bus : register-file channels
//   busy       : arbiter is in the middle of an access
// Modports:
//   master : the environment (host, core and register file)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface can_reg_access_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic              host_err;
   logic [DATA_W-1:0] host_rdata;

   logic              core_req;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_ack;

   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] bus_data;
   logic [DATA_W-1:0] reg_r_bus;

   logic              busy;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_err, host_rdata,
      output core_req, core_addr, core_wdata,
      input  core_ack,
      input  wr_en, rd_en, addr, bus_data,
      output reg_r_bus,
      input  busy
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_err, host_rdata,
      input  core_req, core_addr, core_wdata,
      output core_ack,
      output wr_en, rd_en, addr, bus_data,
      input  reg_r_bus,
      output busy
   );

endinterface

// File: rtl/can_reg_access_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// can_rr_arb2
// Two-way round-robin arbiter between the host bus and the CAN core.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req_host   : host is requesting
//   req_core   : core is requesting
//   update     : the FSM accepted the current grant this cycle
//   any_req    : at least one requester is active
//   grant      : requester that wins if the FSM accepts now
// ---------------------------------------------------------------------------
module can_rr_arb2
   import can_reg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_host,
   input  logic req_core,
   input  logic update,
   output logic any_req,
   output src_t grant
);

   src_t last_grant;

   // A lone requester always wins; under contention the one that was not
   // served last goes first. Since last_grant resets to the host, the core
   // wins the first contention after reset.
   always_comb begin
      any_req = req_host | req_core;
      grant   = SRC_HOST;
      if (req_host && req_core) begin
         grant = (last_grant == SRC_HOST) ? SRC_CORE : SRC_HOST;
      end else if (req_core) begin
         grant = SRC_CORE;
      end
   end

   // Remember the winner only when the FSM actually starts the access
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= SRC_HOST;
      end else if (update) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/can_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// can_reg_access_arbiter
// Serialises host-bus and CAN-core accesses onto the register-file
// write/read channels. Each access is one strobe, ACC_WAIT wait cycles
// and a single-cycle acknowledge to the requester that won arbitration.
// Addresses are checked against the register map before any strobe.
// Parameters:
//   ADDR_W   : register address width
//   DATA_W   : register data width
//   ACC_WAIT : wait cycles between strobe and response (0..7)
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave side of can_reg_access_arbiter_if (requests, responses,
//          register-file channels and busy flag)
// ---------------------------------------------------------------------------
module can_reg_access_arbiter
   import can_reg_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int ACC_WAIT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   can_reg_access_arbiter_if.slave  bus
);

   localparam bit HAS_WAIT = (ACC_WAIT > 0);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
      HAS_WAIT ? WAIT_CNT_W'(ACC_WAIT - 1) : '0;

   state_t                state;
   src_t                  src;
   logic                  lat_we;
   logic                  lat_valid;
   logic [WAIT_CNT_W-1:0] wait_cnt;

   logic                  wr_en_q;
   logic                  rd_en_q;
   logic                  host_ack_q;
   logic                  host_err_q;
   logic                  core_ack_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     bus_data_q;
   logic [DATA_W-1:0]     rdata_q;
   logic                  busy_q;

   logic                  any_req;
   logic                  accept;
   src_t                  grant;
   logic                  sel_we;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_data;
   logic                  sel_valid;
   logic                  to_resp;

   // Starting an access is what moves the round-robin pointer
   assign accept = (state == IDLE) && any_req;

   can_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_host (bus.host_req),
      .req_core (bus.core_req),
      .update   (accept),
      .any_req  (any_req),
      .grant    (grant)
   );

   // Pick the winner's access fields and decide up front whether the
   // address is legal for that direction. The core only ever writes.
   always_comb begin
      sel_we   = 1'b1;
      sel_addr = bus.core_addr;
      sel_data = bus.core_wdata;
      if (grant == SRC_HOST) begin
         sel_we   = bus.host_we;
         sel_addr = bus.host_addr;
         sel_data = bus.host_wdata;
      end
      sel_valid = sel_we ? is_wr_addr_valid(32'(sel_addr))
                         : is_rd_addr_valid(32'(sel_addr));
   end

   // The last ACCESS/WAIT cycle: either ACCESS with no wait configured, or
   // the final counted WAIT cycle. The edge leaving it enters RESP.
   assign to_resp = ((state == ACCESS) && !HAS_WAIT) ||
                    ((state == WAIT) && (wait_cnt == WAIT_LAST));

   // Main sequencer. All outputs are registered here so they line up with
   // the state they belong to: the write strobe is a one-cycle pulse in
   // ACCESS, the read strobe is held from ACCESS through WAIT, and the
   // acknowledge pulses during RESP. Read data is captured on the edge into
   // RESP so the register file has had the whole wait to respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src        <= SRC_HOST;
         lat_we     <= 1'b0;
         lat_valid  <= 1'b0;
         wait_cnt   <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         host_ack_q <= 1'b0;
         host_err_q <= 1'b0;
         core_ack_q <= 1'b0;
         addr_q     <= '0;
         bus_data_q <= '0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         wr_en_q    <= 1'b0;
         host_ack_q <= 1'b0;
         host_err_q <= 1'b0;
         core_ack_q <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= ACCESS;
                  src        <= grant;
                  lat_we     <= sel_we;
                  lat_valid  <= sel_valid;
                  wr_en_q    <= sel_we && sel_valid;
                  rd_en_q    <= !sel_we && sel_valid;
                  addr_q     <= sel_addr;
                  bus_data_q <= sel_data;
                  busy_q     <= 1'b1;
               end
            end

            ACCESS: begin
               if (HAS_WAIT) begin
                  state    <= WAIT;
                  wait_cnt <= '0;
               end
            end

            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
            end

            RESP: begin
               state      <= IDLE;
               addr_q     <= '0;
               bus_data_q <= '0;
               busy_q     <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase

         // An invalid core write is dropped without a strobe but still
         // acknowledged; an invalid host access is flagged with host_err
         // and an invalid host read returns zero.
         if (to_resp) begin
            state      <= RESP;
            rd_en_q    <= 1'b0;
            host_ack_q <= (src == SRC_HOST);
            core_ack_q <= (src == SRC_CORE);
            host_err_q <= (src == SRC_HOST) && !lat_valid;
            if ((src == SRC_HOST) && !lat_we) begin
               rdata_q <= lat_valid ? bus.reg_r_bus : '0;
            end
         end
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.rd_en      = rd_en_q;
   assign bus.addr       = addr_q;
   assign bus.bus_data   = bus_data_q;
   assign bus.host_ack   = host_ack_q;
   assign bus.host_err   = host_err_q;
   assign bus.host_rdata = rdata_q;
   assign bus.core_ack   = core_ack_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_can_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_can_reg_access_arbiter
// Drives two arbiter instances (ACC_WAIT = 1 and ACC_WAIT = 0) from the same
// request signals and checks whichever one is selected against a
// transaction-level model: arbitration order, strobe timeline, ack timing,
// error flag and read-data capture.
// ---------------------------------------------------------------------------
module tb_can_reg_access_arbiter;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              core_req;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] reg_r_bus;

   can_reg_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
   can_reg_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

   can_reg_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_WAIT(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   can_reg_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_WAIT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   // Both instances see identical stimulus
   assign bus1.host_req  = host_req;   assign bus0.host_req  = host_req;
   assign bus1.host_we   = host_we;    assign bus0.host_we   = host_we;
   assign bus1.host_addr = host_addr;  assign bus0.host_addr = host_addr;
   assign bus1.host_wdata= host_wdata; assign bus0.host_wdata= host_wdata;
   assign bus1.core_req  = core_req;   assign bus0.core_req  = core_req;
   assign bus1.core_addr = core_addr;  assign bus0.core_addr = core_addr;
   assign bus1.core_wdata= core_wdata; assign bus0.core_wdata= core_wdata;
   assign bus1.reg_r_bus = reg_r_bus;  assign bus0.reg_r_bus = reg_r_bus;

   // sel = 1 observes the ACC_WAIT = 1 instance, sel = 0 the other one
   bit sel;

   logic              o_wr, o_rd, o_hack, o_herr, o_cack, o_busy;
   logic [ADDR_W-1:0] o_addr;
   logic [DATA_W-1:0] o_bdata, o_rdata;

   assign o_wr    = sel ? bus1.wr_en      : bus0.wr_en;
   assign o_rd    = sel ? bus1.rd_en      : bus0.rd_en;
   assign o_hack  = sel ? bus1.host_ack   : bus0.host_ack;
   assign o_herr  = sel ? bus1.host_err   : bus0.host_err;
   assign o_cack  = sel ? bus1.core_ack   : bus0.core_ack;
   assign o_busy  = sel ? bus1.busy       : bus0.busy;
   assign o_addr  = sel ? bus1.addr       : bus0.addr;
   assign o_bdata = sel ? bus1.bus_data   : bus0.bus_data;
   assign o_rdata = sel ? bus1.host_rdata : bus0.host_rdata;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit                last_core;
   logic [DATA_W-1:0] exp_rdata;

   // Register map, written straight from the address list
   function automatic bit wr_ok(input logic [ADDR_W-1:0] a);
      int v;
      v = int'(a);
      return v inside {[0:3], 5, [8:17], [24:32]};
   endfunction

   function automatic bit rd_ok(input logic [ADDR_W-1:0] a);
      return int'(a) <= 32;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_cycle(input string ph, input logic wr, input logic rd,
                              input logic hack, input logic herr, input logic cack,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [DATA_W-1:0] rdat, input logic busy);
      check_output({ph, ".wr_en"},    32'(o_wr),    32'(wr));
      check_output({ph, ".rd_en"},    32'(o_rd),    32'(rd));
      check_output({ph, ".host_ack"}, 32'(o_hack),  32'(hack));
      check_output({ph, ".host_err"}, 32'(o_herr),  32'(herr));
      check_output({ph, ".core_ack"}, 32'(o_cack),  32'(cack));
      check_output({ph, ".addr"},     32'(o_addr),  32'(a));
      check_output({ph, ".bus_data"}, o_bdata,      d);
      check_output({ph, ".rdata"},    o_rdata,      rdat);
      check_output({ph, ".busy"},     32'(o_busy),  32'(busy));
   endtask

   task automatic apply_stimulus(input logic hr, input logic hw, input logic [ADDR_W-1:0] ha,
                                 input logic [DATA_W-1:0] hd, input logic cr,
                                 input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
      host_req   = hr;
      host_we    = hw;
      host_addr  = ha;
      host_wdata = hd;
      core_req   = cr;
      core_addr  = ca;
      core_wdata = cd;
   endtask

   // Follows one access from the IDLE cycle in which it is sampled to the
   // IDLE cycle after its ack. Called at a negedge inside that IDLE cycle.
   task automatic serve(input bit is_core, input bit fixed_bus, input bit early_drop);
      logic              we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] cap;
      bit                ok;
      int                wn;
      wn = sel ? 1 : 0;
      if (is_core) begin
         we = 1'b1; a = core_addr; d = core_wdata;
      end else begin
         we = host_we; a = host_addr; d = host_wdata;
      end
      ok  = we ? wr_ok(a) : rd_ok(a);
      cap = reg_r_bus;
      for (int k = 1; k <= wn + 2; k++) begin
         @(negedge clk);
         if (k == 1) last_core = is_core;
         if (k == wn + 2) begin
            if (!is_core && !we) exp_rdata = ok ? cap : '0;
            check_cycle("resp", 1'b0, 1'b0, !is_core, !is_core && !ok, is_core,
                        a, d, exp_rdata, 1'b1);
            if (is_core) core_req = 1'b0; else host_req = 1'b0;
         end else begin
            check_cycle((k == 1) ? "access" : "wait", (k == 1) && we && ok, !we && ok,
                        1'b0, 1'b0, 1'b0, a, d, exp_rdata, 1'b1);
         end
         // Winner's fields are latched; disturbing them must not matter
         if (k == 1) begin
            if (is_core) begin
               core_addr  = ADDR_W'($urandom);
               core_wdata = $urandom;
               if (early_drop) core_req = 1'b0;
            end else begin
               host_we    = 1'($urandom);
               host_addr  = ADDR_W'($urandom);
               host_wdata = $urandom;
               if (early_drop) host_req = 1'b0;
            end
         end
         if (!fixed_bus && (k <= wn + 1)) reg_r_bus = $urandom;
         if (k == wn + 1) cap = reg_r_bus;
      end
      @(negedge clk);
      check_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, exp_rdata, 1'b0);
   endtask

   task automatic run_round(input logic hr, input logic hw, input logic [ADDR_W-1:0] ha,
                            input logic [DATA_W-1:0] hd, input logic cr,
                            input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                            input bit fixed_bus, input logic [DATA_W-1:0] bus_val,
                            input bit early_drop);
      bit first_core;
      apply_stimulus(hr, hw, ha, hd, cr, ca, cd);
      reg_r_bus = fixed_bus ? bus_val : $urandom;
      if (!hr && !cr) begin
         @(negedge clk);
         check_cycle("norq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, exp_rdata, 1'b0);
         return;
      end
      first_core = (hr && cr) ? !last_core : cr;
      serve(first_core, fixed_bus, early_drop);
      if (hr && cr) serve(!first_core, fixed_bus, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      reg_r_bus = '0;
      repeat (2) @(negedge clk);
      check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      rst       = 1'b0;
      last_core = 1'b0;
      exp_rdata = '0;
   endtask

   task automatic random_rounds(input int n);
      for (int i = 0; i < n; i++) begin
         logic [ADDR_W-1:0] ha, ca;
         ha = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 33)) : ADDR_W'($urandom);
         ca = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 33)) : ADDR_W'($urandom);
         run_round(1'($urandom), 1'($urandom), ha, $urandom,
                   1'($urandom), ca, $urandom,
                   1'b0, '0, $urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      sel = 1'b1;
      do_reset();

      // ACC_WAIT = 1: directed host accesses
      run_round(1'b1, 1'b1, 6'h05, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      run_round(1'b1, 1'b0, 6'h10, 32'h0, 1'b0, '0, '0, 1'b1, 32'h12345678, 1'b0);
      run_round(1'b1, 1'b1, 6'h04, 32'hCAFEF00D, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      run_round(1'b1, 1'b0, 6'h21, 32'h0, 1'b0, '0, '0, 1'b1, 32'h55AA55AA, 1'b0);

      // Contention, twice in a row, right after a reset
      do_reset();
      run_round(1'b1, 1'b1, 6'h09, 32'h11111111, 1'b1, 6'h0A, 32'h22222222, 1'b0, '0, 1'b0);
      run_round(1'b1, 1'b0, 6'h1F, 32'h0, 1'b1, 6'h20, 32'h33333333, 1'b0, '0, 1'b0);
      random_rounds(40);

      // ACC_WAIT = 0 instance
      sel = 1'b0;
      do_reset();
      run_round(1'b0, 1'b0, '0, '0, 1'b1, 6'h18, 32'hA0B0C0D0, 1'b0, '0, 1'b0);
      run_round(1'b1, 1'b0, 6'h02, 32'h0, 1'b1, 6'h07, 32'h44444444, 1'b0, '0, 1'b0);
      random_rounds(30);

      // Reset during the WAIT cycle of a host read aborts it
      sel = 1'b1;
      do_reset();
      run_round(1'b1, 1'b0, 6'h10, 32'h0, 1'b0, '0, '0, 1'b1, 32'h12345678, 1'b0);
      apply_stimulus(1'b1, 1'b0, 6'h03, 32'h0, 1'b0, '0, '0);
      reg_r_bus = 32'hA5A5A5A5;
      @(negedge clk);
      check_cycle("abort.access", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h03, '0, exp_rdata, 1'b1);
      @(negedge clk);
      check_cycle("abort.wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h03, '0, exp_rdata, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_cycle("abort.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      rst       = 1'b0;
      last_core = 1'b0;
      exp_rdata = '0;
      run_round(1'b1, 1'b0, 6'h07, 32'h0, 1'b1, 6'h09, 32'h66666666, 1'b0, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
